// File: rtl/instr_decode_stage.sv
// Decode stage: turns 9-bit machine words into registered ALU/regfile/memory control bundles.
// Define ILLEGAL_TRAP_EN to make undefined opcodes halt the program like END.
//
// state   | meaning
// IDLE    | after reset, waiting for Start
// RUN     | accepting and decoding instructions
// MEMWAIT | stalled after accepting LDR/STR
// HALT    | END accepted, Ack high until Start
module instr_decode_stage #(
  parameter int INST_W          = 9,
  parameter int MEM_WAIT_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              InstValid,
  input  logic [INST_W-1:0] Instruction,
  output logic              InstReady,
  output logic              DecValid,
  input  logic              DecReady,
  output logic [3:0]        AluOp,
  output logic [4:0]        Operand,
  output logic              RegWrite,
  output logic              FlagWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [1:0]        BranchType,
  output logic              Illegal,
  output logic              Ack,
  output logic [CNT_W-1:0]  InstCount
);

  localparam int WAIT_W = (MEM_WAIT_CYCLES < 2) ? 1 : $clog2(MEM_WAIT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_MEMWAIT, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [3:0] opcode;
  logic [3:0] dec_alu;
  logic       dec_rw, dec_fw, dec_mr, dec_mw, dec_ill;
  logic [1:0] dec_br;
  logic       op_halt, op_mem;
  logic       accept, handoff, restart;

  assign opcode = Instruction[INST_W-1 -: 4];

  always_comb begin
    dec_alu = 4'd0;
    dec_rw  = 1'b0;
    dec_fw  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_br  = 2'b00;
    dec_ill = 1'b0;
    case (opcode)
      4'b0001: begin dec_alu = 4'd1; dec_rw = 1'b1; end
      4'b0010: begin dec_alu = 4'd2; dec_rw = 1'b1; end
      4'b0011: begin dec_alu = 4'd3; dec_rw = 1'b1; end
      4'b0100: begin dec_alu = 4'd4; dec_rw = 1'b1; end
      4'b0101: begin dec_alu = 4'd5; dec_rw = 1'b1; end
      4'b0110: begin dec_alu = 4'd6; dec_fw = 1'b1; end
      4'b0111: begin dec_alu = 4'd7; dec_rw = 1'b1; end
      4'b1001: dec_br = 2'b01;
      4'b1010: dec_br = 2'b10;
      4'b1011: dec_br = 2'b11;
      4'b1100: begin dec_mr = 1'b1; dec_rw = 1'b1; end
      4'b1101: dec_mw = 1'b1;
      4'b1000, 4'b1110, 4'b1111: dec_ill = 1'b1;
      default: ;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign op_halt = (opcode == 4'b0000) || dec_ill;
`else
  assign op_halt = (opcode == 4'b0000);
`endif
  assign op_mem = dec_mr || dec_mw;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    InstReady = (state_q == S_RUN) && (!DecValid || DecReady);
    Ack       = (state_q == S_HALT);
    accept    = InstValid && InstReady;
    handoff   = DecValid && DecReady;
    restart   = 1'b0;
    case (state_q)
      S_IDLE: if (Start) begin state_d = S_RUN; restart = 1'b1; end
      S_RUN: begin
        if (accept) begin
          if (op_halt) begin
            state_d = S_HALT;
          end else if (op_mem && (MEM_WAIT_CYCLES > 0)) begin
            state_d = S_MEMWAIT;
            wait_d  = WAIT_INIT;
          end
        end
      end
      S_MEMWAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q <= 1) state_d = S_RUN;
      end
      S_HALT: if (Start) begin state_d = S_RUN; restart = 1'b1; end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      DecValid   <= 1'b0;
      AluOp      <= 4'd0;
      Operand    <= 5'd0;
      RegWrite   <= 1'b0;
      FlagWrite  <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      BranchType <= 2'b00;
      Illegal    <= 1'b0;
      InstCount  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      // Bundle only changes on accept, so a stalled handoff holds it stable.
      if (accept) begin
        DecValid   <= 1'b1;
        AluOp      <= dec_alu;
        Operand    <= Instruction[4:0];
        RegWrite   <= dec_rw;
        FlagWrite  <= dec_fw;
        MemRead    <= dec_mr;
        MemWrite   <= dec_mw;
        BranchType <= dec_br;
        Illegal    <= dec_ill;
      end else if (handoff) begin
        DecValid <= 1'b0;
      end
      if (restart)      InstCount <= '0;
      else if (handoff) InstCount <= InstCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: directed program plus randomized stream
// against a table-level reference model. Honors ILLEGAL_TRAP_EN like the design.
module tb_instr_decode_stage;
  localparam int MW    = 2;
  localparam int CNT_W = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  logic             Clk = 1'b0;
  logic             Reset, Start, InstValid, DecReady;
  logic [8:0]       Instruction;
  logic             InstReady, DecValid, RegWrite, FlagWrite, MemRead, MemWrite, Illegal, Ack;
  logic [3:0]       AluOp;
  logic [4:0]       Operand;
  logic [1:0]       BranchType;
  logic [CNT_W-1:0] InstCount;

  typedef struct packed {
    logic [3:0] alu;
    logic [4:0] opnd;
    logic       rw, fw, mr, mw;
    logic [1:0] br;
    logic       ill;
  } bundle_t;

  bundle_t          sb[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_cnt  = '0;
  int               mode     = M_IDLE;
  int               wait_left = 0;

  instr_decode_stage #(.INST_W(9), .MEM_WAIT_CYCLES(MW), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InstValid(InstValid),
    .Instruction(Instruction), .InstReady(InstReady), .DecValid(DecValid),
    .DecReady(DecReady), .AluOp(AluOp), .Operand(Operand), .RegWrite(RegWrite),
    .FlagWrite(FlagWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .BranchType(BranchType), .Illegal(Illegal), .Ack(Ack), .InstCount(InstCount)
  );

  always #5 Clk = ~Clk;

  // ALU ops 0..7 share their opcode value; branches are opcode-8.
  function automatic bundle_t ref_decode(input logic [8:0] w);
    int op;
    bundle_t b;
    op = int'(w[8:5]);
    b = '0;
    b.opnd = w[4:0];
    if (op <= 7) b.alu = 4'(op);
    b.rw  = op inside {[1:5], 7, 12};
    b.fw  = (op == 6);
    b.mr  = (op == 12);
    b.mw  = (op == 13);
    if (op inside {[9:11]}) b.br = 2'(op - 8);
    b.ill = op inside {8, 14, 15};
    return b;
  endfunction

  function automatic bit halts(input logic [8:0] w);
`ifdef ILLEGAL_TRAP_EN
    return (w[8:5] == 4'd0) || (w[8:5] inside {4'd8, 4'd14, 4'd15});
`else
    return (w[8:5] == 4'd0);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input logic iv, input logic [8:0] ins, input logic dr,
                      input logic st, input logic rst, output logic acc);
    logic exp_ready;
    int   mode_before;
    mode_before = mode;
    Reset = rst; Start = st; InstValid = iv; Instruction = ins; DecReady = dr;
    @(negedge Clk);
    exp_ready = (mode == M_RUN) && (wait_left == 0) && (sb.size() == 0 || dr);
    if (!rst) begin
      chk("inst_ready", InstReady, exp_ready);
      chk("ack", Ack, mode == M_HALT);
    end
    acc = !rst && iv && exp_ready;
    @(posedge Clk); #1;
    if (rst) begin
      mode = M_IDLE; wait_left = 0; sb.delete(); exp_cnt = '0;
    end else begin
      if (acc) begin
        sb.push_back(ref_decode(ins));
        if (halts(ins)) mode = M_HALT;
        else if ((ins[8:5] == 4'd12 || ins[8:5] == 4'd13) && MW > 0) wait_left = MW;
      end else if (wait_left > 0) begin
        wait_left--;
      end
      if (st && (mode_before == M_IDLE || mode_before == M_HALT)) begin
        mode = M_RUN; exp_cnt = '0;
      end
    end
  endtask

  task automatic issue(input logic [8:0] ins);
    logic acc;
    int n;
    n = 0;
    do begin
      step(1'b1, ins, 1'b1, 1'b0, 1'b0, acc);
      n++;
    end while (!acc && n < 20);
    if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle(input int n, input logic dr);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 9'd0, dr, 1'b0, 1'b0, acc);
  endtask

  task automatic check_zero();
    chk("rst_inst_ready", InstReady, 0);
    chk("rst_dec_valid", DecValid, 0);
    chk("rst_alu_op", AluOp, 0);
    chk("rst_operand", Operand, 0);
    chk("rst_enables", {RegWrite, FlagWrite, MemRead, MemWrite}, 0);
    chk("rst_branch", BranchType, 0);
    chk("rst_illegal", Illegal, 0);
    chk("rst_ack", Ack, 0);
    chk("rst_count", InstCount, 0);
  endtask

  // Monitor: compares the presented bundle with the oldest expected one, pops on handoff.
  initial begin
    forever begin
      @(negedge Clk);
      if (Reset !== 1'b0) continue;
      chk("dec_valid", DecValid, sb.size() != 0);
      chk("inst_count", InstCount, exp_cnt);
      if (DecValid && sb.size() != 0) begin
        chk("alu_op", AluOp, sb[0].alu);
        chk("operand", Operand, sb[0].opnd);
        chk("reg_write", RegWrite, sb[0].rw);
        chk("flag_write", FlagWrite, sb[0].fw);
        chk("mem_read", MemRead, sb[0].mr);
        chk("mem_write", MemWrite, sb[0].mw);
        chk("branch_type", BranchType, sb[0].br);
        chk("illegal", Illegal, sb[0].ill);
        if (DecReady) begin
          void'(sb.pop_front());
          exp_cnt = exp_cnt + 1'b1;
        end
      end
    end
  end

  initial begin
    logic acc;
    logic [3:0] op;
    int n;
    Reset = 1'b1; Start = 1'b0; InstValid = 1'b0; Instruction = '0; DecReady = 1'b0;
    step(1'b0, 9'd0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, 9'd0, 1'b0, 1'b0, 1'b1, acc);
    check_zero();
    step(1'b0, 9'd0, 1'b1, 1'b1, 1'b0, acc);

    issue(9'b0001_00011);
    issue(9'b0011_00101);
    idle(2, 1'b1);
    chk("count_mov_add", InstCount, 2);
    issue(9'b0110_00001);
    issue(9'b1010_00100);
    issue(9'b1100_00111);
    issue(9'b1101_01000);

    // Stalled handoff: bundle must hold and the stage must refuse new words.
    issue(9'b0100_10001);
    for (int i = 0; i < 3; i++) step(1'b1, 9'b0011_00001, 1'b0, 1'b0, 1'b0, acc);
    idle(2, 1'b1);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(1, 15));
`ifdef ILLEGAL_TRAP_EN
      if (op inside {4'd8, 4'd14, 4'd15}) op = 4'd3;
`endif
      step($urandom_range(0, 3) != 0, {op, 5'($urandom)}, $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0, 1'b0, acc);
    end
    idle(4, 1'b1);

    issue(9'b1110_01010);
    idle(3, 1'b1);
`ifdef ILLEGAL_TRAP_EN
    chk("trap_ack", Ack, 1);
    step(1'b0, 9'd0, 1'b1, 1'b1, 1'b0, acc);
`endif
    issue(9'b0101_00110);

    issue(9'b0000_00000);
    n = 0;
    while (sb.size() != 0 && n < 10) begin idle(1, 1'b1); n++; end
    idle(2, 1'b1);
    chk("end_ack", Ack, 1);
    chk("end_ready", InstReady, 0);
    step(1'b0, 9'd0, 1'b1, 1'b1, 1'b0, acc);
    chk("restart_ack", Ack, 0);
    chk("restart_count", InstCount, 0);

    issue(9'b1100_00010);
    step(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b0, 9'd0, 1'b0, 1'b0, 1'b1, acc);
    check_zero();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Sequential decode stage that consumes 9-bit machine words from fetch and produces registered control bundles for the ALU, register file and data memory.
- Reads the team's instruction map: opcode field Instruction[8:5], operand field Instruction[4:0].
- Owns program-level sequencing: Start/Ack, a stall for memory ops, halt on END, and a retired-instruction counter.

Parameters:
- INST_W, 9, instruction word width (opcode = top 4 bits).
- MEM_WAIT_CYCLES, 1, extra cycles InstReady stays low after accepting LDR/STR (0 = no stall).
- CNT_W, 16, width of InstCount.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin decoding (pulse).
- InstValid  in  1  fetch presents Instruction.
- Instruction  in  INST_W  machine word.
- InstReady  out  1  stage accepts word this cycle.
- DecValid  out  1  decoded bundle valid.
- DecReady  in  1  downstream accepts bundle.
- AluOp  out  4  op_mne encoding: END=0, MOV=1, LSF=2, ADD=3, SUB=4, XOR=5, CMP=6, PAR=7.
- Operand  out  5  Instruction[4:0], registered.
- RegWrite  out  1  register write enable.
- FlagWrite  out  1  compare-flag write enable.
- MemRead  out  1  data-memory read.
- MemWrite  out  1  data-memory write.
- BranchType  out  2  00 none, 01 BNE, 10 BLT, 11 BGT.
- Illegal  out  1  bundle came from an undefined opcode.
- Ack  out  1  program finished (HALT state).
- InstCount  out  CNT_W  bundles handed downstream since Start.

Behaviour:
- Reset: state=IDLE; all outputs 0; counters 0.
- States: IDLE, RUN, MEMWAIT, HALT.
  - IDLE->RUN on Start.
  - HALT->RUN on Start, clearing Ack and InstCount.
  - Start is ignored in RUN and MEMWAIT.
- Accept: InstValid && InstReady at an edge.
  - InstReady = (state==RUN) && (!DecValid || DecReady).
  - Decoded bundle is registered; DecValid rises the cycle after accept (latency 1).
- Hold: while DecValid && !DecReady, all bundle outputs are held stable.
- Clear: DecValid drops after a handoff (DecValid && DecReady) with no new accept that cycle.
- InstCount increments once per handoff; wraps at 2^CNT_W-1 -> 0.
- Decode table (fields not listed are 0):
  - 0001 MOV: AluOp=MOV, RegWrite.
  - 0010 LFS: AluOp=LSF, RegWrite.
  - 0011 ADD / 0100 SUB / 0101 XOR / 0111 PAR: matching AluOp, RegWrite.
  - 0110 CMP: AluOp=CMP, FlagWrite.
  - 1001/1010/1011: BranchType 01/10/11, AluOp=END.
  - 1100 LDR: MemRead, RegWrite.
  - 1101 STR: MemWrite.
  - 0000 END: AluOp=END, all enables 0.
  - 1000, 1110, 1111: Illegal=1, all enables 0 (NOP).
- Memory ops: accepting LDR/STR with MEM_WAIT_CYCLES>0 enters MEMWAIT, loading the wait counter with MEM_WAIT_CYCLES.
  - InstReady=0 in MEMWAIT.
  - Counter decrements each cycle; at 1 -> RUN next edge.
  - With MEM_WAIT_CYCLES=0, state stays RUN.
- END: accept -> HALT immediately; no further accepts.
  - The END bundle is still delivered (DecValid until DecReady).
  - Ack=1 from the cycle after accept until Start or Reset.
- Reset asserted mid-operation (any state, including a held bundle) returns everything to reset values on that edge; a pending bundle is discarded.
- Reset has priority over Start.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an accepted illegal opcode behaves like END.
  - Bundle is delivered with Illegal=1; state -> HALT; Ack=1.
- Undefined: illegal opcode is a NOP bundle with Illegal=1 and decoding continues in RUN.

Test Plan:
- Reset, Start, stream MOV 9'b0001_00011, ADD 9'b0011_00101, DecReady=1 -> DecValid one cycle after each accept, AluOp 1 then 3, RegWrite=1, Operand 3 then 5, InstCount=2.
- CMP 9'b0110_00001 then BLT 9'b1010_00100 -> FlagWrite=1/RegWrite=0, then BranchType=10, AluOp=0.
- LDR with MEM_WAIT_CYCLES=2 -> InstReady low exactly 2 cycles after accept, MemRead=RegWrite=1; STR -> MemWrite=1 only.
- DecReady held 0 for 3 cycles with DecValid=1 -> InstReady=0, outputs frozen, InstCount unchanged; DecReady=1 -> handoff, count +1.
- Opcode 1110 -> Illegal=1, no enables; without macro decoding continues, with ILLEGAL_TRAP_EN Ack=1 next cycle.
- END 9'b0000_00000 -> Ack=1 next cycle, InstReady=0; Start -> Ack=0, InstCount=0; Reset during MEMWAIT -> IDLE, all outputs 0.
